// File: rtl/simple_proc2_pkg.sv
// Shared opcode/state encodings, flag bit positions and instruction field positions
// for the simple_proc2 accumulator processor.
package simple_proc2_pkg;

    typedef enum logic [3:0] {
        OP_HLT = 4'h0,
        OP_BRA = 4'h1,
        OP_NOP = 4'h2,
        OP_ST  = 4'h3,
        OP_SHF = 4'h4,
        OP_CPL = 4'h5,
        OP_ADD = 4'h6,
        OP_MUL = 4'h7,
        OP_LD  = 4'h8,
        OP_FSH = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    localparam int FLG_ALWAYS = 0;
    localparam int FLG_CARRY  = 1;
    localparam int FLG_EVEN   = 2;
    localparam int FLG_PARITY = 3;
    localparam int FLG_ZERO   = 4;
    localparam int FLG_NEG    = 5;

    localparam logic [5:0] SR_RESET = 6'b000001;

    localparam int IR_OP_MSB  = 31;
    localparam int IR_OP_LSB  = 28;
    localparam int IR_IM_BIT  = 27;
    localparam int IR_CC_MSB  = 27;
    localparam int IR_CC_LSB  = 24;
    localparam int IR_RD_MSB  = 23;
    localparam int IR_RD_LSB  = 20;
    localparam int IR_RS_MSB  = 19;
    localparam int IR_RS_LSB  = 16;
    localparam int IR_IMM_MSB = 15;
    localparam int IR_IMM_LSB = 0;

endpackage

// File: rtl/simple_proc2_alu.sv
// Combinational ALU: result (DATA_W+1 bits, top bit = carry), flags and opcode legality.
// Zero latency, no flow control; the multiplier exists only when SIMPLE_PROC2_MUL_EN is defined.
module simple_proc2_alu
    import simple_proc2_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [15:0]       imm,
    input  logic              im,
    output logic [DATA_W:0]   res,
    output logic [5:0]        flags,
    output logic              op_ok
);

    logic [DATA_W-1:0] imm_ext;
    logic [5:0]        amt;

    generate
        if (DATA_W > 16) begin : g_imm_zext
            assign imm_ext = {{(DATA_W-16){1'b0}}, imm};
        end else begin : g_imm_trunc
            assign imm_ext = imm[DATA_W-1:0];
        end
    endgenerate

    assign amt = imm[5:0];

`ifdef SIMPLE_PROC2_MUL_EN
    logic [2*DATA_W-1:0] prod;
    assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

    always_comb begin
        res   = '0;
        op_ok = 1'b1;
        case (op)
            OP_SHF: if (32'(amt) < DATA_W) res = {1'b0, (im ? (a << amt) : (a >> amt))};
            OP_CPL: res = {1'b0, (im ? ~imm_ext : ~b)};
            OP_ADD: res = {1'b0, a} + {1'b0, b};
`ifdef SIMPLE_PROC2_MUL_EN
            OP_MUL: res = {|prod[2*DATA_W-1:DATA_W], prod[DATA_W-1:0]};
`else
            OP_MUL: op_ok = 1'b0;
`endif
            OP_LD:  res = {1'b0, b};
            OP_HLT, OP_BRA, OP_NOP, OP_ST, OP_FSH: res = '0;
            default: op_ok = 1'b0;
        endcase

        flags             = '0;
        flags[FLG_ALWAYS] = 1'b1;
        flags[FLG_CARRY]  = res[DATA_W];
        flags[FLG_EVEN]   = ~res[0];
        flags[FLG_PARITY] = ^res[DATA_W-1:0];
        flags[FLG_ZERO]   = (res[DATA_W-1:0] == '0);
        flags[FLG_NEG]    = res[DATA_W-1];
    end

endmodule

// File: rtl/simple_proc2.sv
// Multi-cycle accumulator processor with program ROM and ready/ack data-memory port; MUL needs SIMPLE_PROC2_MUL_EN.
// Latency: 2 cycles per ALU/BRA/NOP/FSH, 3+w for LD/ST; stalls in MEM while mem_ack is low.
module simple_proc2
    import simple_proc2_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 8,
    parameter int    PC_W      = 8,
    parameter int    NREGS     = 4,
    parameter string INIT_FILE = "instr.txt"
) (
    input  logic              clk,
    input  logic              nrst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              halted,
    output logic              illegal,
    output logic [5:0]        status
);

    localparam int RIDX_W = $clog2(NREGS);

    logic [31:0] rom [0:(1<<PC_W)-1];

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [0:NREGS-1];
    logic [DATA_W-1:0] regs_d [0:NREGS-1];
    logic [5:0]        status_q, status_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              halted_q, halted_d, illegal_q, illegal_d;

    logic [3:0]        op, cc, rd, rs;
    logic              im;
    logic [15:0]       imm;
    logic [RIDX_W-1:0] rd_idx, rs_idx;
    logic [DATA_W-1:0] rd_val, rs_val, alu_b;
    logic [DATA_W:0]   alu_res;
    logic [5:0]        alu_flags;
    logic              alu_op_ok, uses_rd, uses_rs, exec_ok, br_taken, mem_done;
    logic [7:0]        sr_ext;
    logic              unused_carry;

    assign op     = ir_q[IR_OP_MSB:IR_OP_LSB];
    assign cc     = ir_q[IR_CC_MSB:IR_CC_LSB];
    assign im     = ir_q[IR_IM_BIT];
    assign rd     = ir_q[IR_RD_MSB:IR_RD_LSB];
    assign rs     = ir_q[IR_RS_MSB:IR_RS_LSB];
    assign imm    = ir_q[IR_IMM_MSB:IR_IMM_LSB];
    assign rd_idx = rd[RIDX_W-1:0];
    assign rs_idx = rs[RIDX_W-1:0];
    assign rd_val = regs_q[rd_idx];
    assign rs_val = regs_q[rs_idx];
    // In MEM the ALU passes the returned load data through so LD flags come from the written value.
    assign alu_b  = (state_q == S_MEM) ? mem_rdata : rs_val;
    assign sr_ext = {2'b00, status_q};

    simple_proc2_alu #(.DATA_W(DATA_W)) u_alu (
        .op    (op),
        .a     (rd_val),
        .b     (alu_b),
        .imm   (imm),
        .im    (im),
        .res   (alu_res),
        .flags (alu_flags),
        .op_ok (alu_op_ok)
    );

    assign unused_carry = alu_res[DATA_W];

    always_comb begin
        uses_rd = 1'b0;
        uses_rs = 1'b0;
        case (op)
            OP_ST, OP_LD, OP_CPL: begin uses_rd = 1'b1; uses_rs = !im; end
            OP_SHF:               uses_rd = 1'b1;
            OP_ADD, OP_MUL:       begin uses_rd = 1'b1; uses_rs = 1'b1; end
            default: ;
        endcase
    end

    assign exec_ok  = alu_op_ok && !(uses_rd && (32'(rd) >= NREGS)) && !(uses_rs && (32'(rs) >= NREGS));
    assign br_taken = !cc[3] && sr_ext[cc[2:0]];
    assign mem_done = mem_req_q && mem_ack;

    always_ff @(posedge clk) begin
        if (!nrst) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                if (!exec_ok)                        state_d = S_FETCH;
                else if (op == OP_HLT)               state_d = S_HALT;
                else if (op == OP_LD || op == OP_ST) state_d = S_MEM;
                else                                 state_d = S_FETCH;
            end
            S_MEM:   if (mem_done) state_d = S_FETCH;
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        ir_d        = ir_q;
        regs_d      = regs_q;
        status_d    = status_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        halted_d    = halted_q;
        illegal_d   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d = rom[pc_q];
                pc_d = pc_q + 1'b1;
            end
            S_EXEC: begin
                if (!exec_ok) begin
                    illegal_d = 1'b1;
                end else begin
                    case (op)
                        OP_HLT: halted_d = 1'b1;
                        OP_BRA: if (br_taken) pc_d = imm[PC_W-1:0];
                        OP_LD, OP_ST: begin
                            mem_req_d   = 1'b1;
                            mem_we_d    = (op == OP_ST);
                            mem_addr_d  = im ? imm[ADDR_W-1:0] : rs_val[ADDR_W-1:0];
                            mem_wdata_d = rd_val;
                        end
                        OP_SHF, OP_CPL, OP_ADD, OP_MUL: begin
                            regs_d[rd_idx] = alu_res[DATA_W-1:0];
                            status_d       = alu_flags;
                        end
                        OP_FSH: begin
                            for (int i = 0; i < NREGS; i++) regs_d[i] = '0;
                            status_d = alu_flags;
                        end
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                if (mem_done) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        regs_d[rd_idx] = mem_rdata;
                        status_d       = alu_flags;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            pc_q        <= '0;
            ir_q        <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            status_q    <= SR_RESET;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            regs_q      <= regs_d;
            status_q    <= status_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign status    = status_q;

endmodule

// File: tb/tb_simple_proc2.sv
// Directed bench for simple_proc2: programs are written into the ROM, data memory is a small array.
module tb_simple_proc2;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        mem_req, mem_we, mem_ack = 1'b0, halted, illegal;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [5:0]  status;
    logic [31:0] tb_mem [0:255];

    logic        nrst_w = 1'b0;
    logic        ack_w = 1'b0;
    logic [31:0] rdata_w = 32'h0;
    logic        req_w, we_w, halted_w, illegal_w;
    logic [7:0]  addr_w;
    logic [31:0] wdata_w;
    logic [5:0]  status_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[mem_addr];

    simple_proc2 #(.INIT_FILE("")) dut (
        .clk(clk), .nrst(nrst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .halted(halted), .illegal(illegal), .status(status)
    );

    simple_proc2 #(.PC_W(2), .INIT_FILE("")) dut_w (
        .clk(clk), .nrst(nrst_w), .mem_req(req_w), .mem_we(we_w), .mem_addr(addr_w),
        .mem_wdata(wdata_w), .mem_ack(ack_w), .mem_rdata(rdata_w),
        .halted(halted_w), .illegal(illegal_w), .status(status_w)
    );

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] f,
                                        input logic [3:0] rd, input logic [3:0] rs,
                                        input logic [15:0] imm);
        return {op, f, rd, rs, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_prog();
        nrst = 1'b0;
        for (int i = 0; i < 256; i++) dut.rom[i] = 32'h0;
        tick();
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        tick();
        tick();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        checks++; if (status !== 6'b000001) begin failures++; $display("FAIL reset_status: got %b want 000001", status); end
    endtask

    task automatic test_cpl();
        start_prog();
        dut.rom[0] = enc(4'h5, 4'h8, 4'd0, 4'd0, 16'h00FF);
        dut.rom[1] = enc(4'h5, 4'h0, 4'd1, 4'd0, 16'h0000);
        nrst = 1'b1;
        repeat (5) tick();
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL cpl_halted_early: got %b want 0", halted); end
        tick();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL cpl_halted: got %b want 1", halted); end
        checks++; if (dut.regs_q[0] !== 32'hFFFFFF00) begin failures++; $display("FAIL cpl_r0: got %h want FFFFFF00", dut.regs_q[0]); end
        checks++; if (dut.regs_q[1] !== 32'h000000FF) begin failures++; $display("FAIL cpl_r1: got %h want 000000FF", dut.regs_q[1]); end
        checks++; if (status !== 6'b000001) begin failures++; $display("FAIL cpl_status: got %b want 000001", status); end
        repeat (3) tick();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL cpl_halt_sticky: got %b want 1", halted); end
    endtask

    task automatic test_ld_wait();
        start_prog();
        tb_mem[8'h10] = 32'h80000000;
        dut.rom[0] = enc(4'h8, 4'h8, 4'd2, 4'd0, 16'h0010);
        nrst = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h10}) begin
                failures++;
                $display("FAIL ld_req_hold[%0d]: got req=%b we=%b addr=%h want req=1 we=0 addr=10", i, mem_req, mem_we, mem_addr);
            end
            if (i == 3) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL ld_req_drop: got %b want 0", mem_req); end
        checks++; if (dut.regs_q[2] !== 32'h80000000) begin failures++; $display("FAIL ld_r2: got %h want 80000000", dut.regs_q[2]); end
        checks++; if (status !== 6'b101101) begin failures++; $display("FAIL ld_status: got %b want 101101", status); end
    endtask

    task automatic test_add_bra();
        start_prog();
        dut.rom[0]     = enc(4'h5, 4'h8, 4'd0, 4'd0, 16'h0000);
        dut.rom[1]     = enc(4'h5, 4'h8, 4'd1, 4'd0, 16'h0000);
        dut.rom[2]     = enc(4'h4, 4'h0, 4'd1, 4'd0, 16'd31);
        dut.rom[3]     = enc(4'h6, 4'h0, 4'd0, 4'd1, 16'h0000);
        dut.rom[4]     = enc(4'h1, 4'h4, 4'd0, 4'd0, 16'h0020);
        dut.rom[5]     = enc(4'h5, 4'h8, 4'd2, 4'd0, 16'h1234);
        dut.rom[8'h20] = enc(4'h5, 4'h8, 4'd3, 4'd0, 16'h0000);
        dut.rom[8'h21] = enc(4'h4, 4'h8, 4'd3, 4'd0, 16'd32);
        nrst = 1'b1;
        repeat (6) tick();
        checks++; if (dut.regs_q[1] !== 32'h1) begin failures++; $display("FAIL shf_right31: got %h want 00000001", dut.regs_q[1]); end
        repeat (2) tick();
        checks++; if (dut.regs_q[0] !== 32'h0) begin failures++; $display("FAIL add_wrap: got %h want 0", dut.regs_q[0]); end
        checks++; if (status !== 6'b010111) begin failures++; $display("FAIL add_status: got %b want 010111", status); end
        repeat (2) tick();
        checks++; if (dut.pc_q !== 8'h20) begin failures++; $display("FAIL bra_pc: got %h want 20", dut.pc_q); end
        checks++; if (status !== 6'b010111) begin failures++; $display("FAIL bra_flags_kept: got %b want 010111", status); end
        repeat (4) tick();
        checks++; if (dut.regs_q[2] !== 32'h0) begin failures++; $display("FAIL bra_skipped: got %h want 0", dut.regs_q[2]); end
        checks++; if (dut.regs_q[3] !== 32'h0) begin failures++; $display("FAIL shf_ge_width: got %h want 0", dut.regs_q[3]); end
        checks++; if (status !== 6'b010101) begin failures++; $display("FAIL shf_status: got %b want 010101", status); end
        repeat (2) tick();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL bra_halted: got %b want 1", halted); end
    endtask

    task automatic test_st_reset();
        start_prog();
        tb_mem[0] = 32'h00000005;
        tb_mem[1] = 32'h0000CAFE;
        dut.rom[0] = enc(4'h8, 4'h8, 4'd1, 4'd0, 16'h0000);
        dut.rom[1] = enc(4'h8, 4'h8, 4'd0, 4'd0, 16'h0001);
        dut.rom[2] = enc(4'h3, 4'h0, 4'd0, 4'd1, 16'h0000);
        mem_ack = 1'b1;
        nrst = 1'b1;
        repeat (6) tick();
        mem_ack = 1'b0;
        checks++; if (dut.regs_q[1] !== 32'h5) begin failures++; $display("FAIL st_ld_r1: got %h want 5", dut.regs_q[1]); end
        repeat (2) tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h05, 32'h0000CAFE}) begin
            failures++;
            $display("FAIL st_req: got req=%b we=%b addr=%h wdata=%h want 1 1 05 0000CAFE", mem_req, mem_we, mem_addr, mem_wdata);
        end
        tick();
        checks++;
        if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 8'h05, 32'h0000CAFE}) begin
            failures++;
            $display("FAIL st_stable: got req=%b addr=%h wdata=%h want 1 05 0000CAFE", mem_req, mem_addr, mem_wdata);
        end
        nrst = 1'b0;
        tick();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL st_reset_req: got %b want 0", mem_req); end
        checks++; if (dut.regs_q[0] !== 32'h0) begin failures++; $display("FAIL st_reset_regs: got %h want 0", dut.regs_q[0]); end
    endtask

    task automatic test_illegal();
        int pulses;
        int exp_pulses;
        logic [31:0] exp_r3;
        logic [5:0]  exp_sr;
`ifdef SIMPLE_PROC2_MUL_EN
        exp_pulses = 2; exp_r3 = 32'h0;        exp_sr = 6'b010111;
`else
        exp_pulses = 3; exp_r3 = 32'h00010000; exp_sr = 6'b001101;
`endif
        pulses = 0;
        start_prog();
        tb_mem[2] = 32'h00010000;
        dut.rom[0] = enc(4'hA, 4'h0, 4'd0, 4'd0, 16'h0000);
        dut.rom[1] = enc(4'h8, 4'h8, 4'd3, 4'd0, 16'h0002);
        dut.rom[2] = enc(4'h7, 4'h0, 4'd3, 4'd3, 16'h0000);
        dut.rom[3] = enc(4'h6, 4'h0, 4'd5, 4'd0, 16'h0000);
        mem_ack = 1'b1;
        nrst = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (illegal === 1'b1) pulses++;
            if (i == 2) begin
                checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ill_pulse_on: got %b want 1", illegal); end
            end
            if (i == 3) begin
                checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL ill_pulse_off: got %b want 0", illegal); end
            end
        end
        mem_ack = 1'b0;
        checks++; if (pulses !== exp_pulses) begin failures++; $display("FAIL ill_count: got %0d want %0d", pulses, exp_pulses); end
        checks++; if (dut.regs_q[3] !== exp_r3) begin failures++; $display("FAIL mul_r3: got %h want %h", dut.regs_q[3], exp_r3); end
        checks++; if (status !== exp_sr) begin failures++; $display("FAIL mul_status: got %b want %b", status, exp_sr); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL ill_halted: got %b want 1", halted); end
    endtask

    task automatic test_pc_wrap();
        logic [1:0] exp_pc [0:4];
        exp_pc = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) dut_w.rom[i] = enc(4'h2, 4'h0, 4'd0, 4'd0, 16'h0000);
        nrst_w = 1'b0;
        tick();
        nrst_w = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (dut_w.pc_q !== exp_pc[k]) begin failures++; $display("FAIL pc_wrap[%0d]: got %0d want %0d", k, dut_w.pc_q, exp_pc[k]); end
            tick();
            tick();
        end
        checks++; if (halted_w !== 1'b0) begin failures++; $display("FAIL pc_wrap_halted: got %b want 0", halted_w); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
        test_reset();
        test_cpl();
        test_ld_wait();
        test_add_bra();
        test_st_reset();
        test_illegal();
        test_pc_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
